// File: rtl/clock_period_meter.sv
// clock_period_meter: SIG_IN period/high time in CLK_IN cycles; hcnt/HIGH_TIME only with CLOCK_PERIOD_METER_DUTY_EN.
// Latency: VALID 3 CLK_IN edges after the SIG_IN rise; outputs hold between VALID pulses.
// No backpressure: VALID is a one-cycle pulse, TIMEOUT stays set until the next VALID or RESET.
module clock_period_meter #(
  parameter logic [27:0] MAX_COUNT = 28'd100_000_000
) (
  input  logic        CLK_IN,
  input  logic        RESET,
  input  logic        SIG_IN,
  output logic [27:0] PERIOD,
  output logic [27:0] LOAD_EST,
  output logic [27:0] HIGH_TIME,
  output logic        VALID,
  output logic        TIMEOUT
);

  typedef enum logic [1:0] {WAIT_LOW, ARM, COUNT} state_t;

  state_t      state, state_nxt;
  logic        s1, s2, s3;
  logic [1:0]  fill;
  logic [27:0] cnt, cnt_nxt;
  logic [27:0] period_nxt, load_nxt;
  logic        valid_nxt, timeout_nxt;
  logic        rise, primed;

  assign rise   = s2 & ~s3;
  // s2 carries its reset value for two edges; a low only counts once real samples arrive
  assign primed = fill[1];

`ifdef CLOCK_PERIOD_METER_DUTY_EN
  logic [27:0] hcnt, hcnt_nxt, high_nxt;
`endif

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      fill     <= 2'b00;
      state    <= WAIT_LOW;
      cnt      <= '0;
      PERIOD   <= '0;
      LOAD_EST <= '0;
      VALID    <= 1'b0;
      TIMEOUT  <= 1'b0;
    end else begin
      s1       <= SIG_IN;
      s2       <= s1;
      s3       <= s2;
      fill     <= {fill[0], 1'b1};
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      PERIOD   <= period_nxt;
      LOAD_EST <= load_nxt;
      VALID    <= valid_nxt;
      TIMEOUT  <= timeout_nxt;
    end
  end

`ifdef CLOCK_PERIOD_METER_DUTY_EN
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      hcnt      <= '0;
      HIGH_TIME <= '0;
    end else begin
      hcnt      <= hcnt_nxt;
      HIGH_TIME <= high_nxt;
    end
  end
`else
  assign HIGH_TIME = 28'd0;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    period_nxt  = PERIOD;
    load_nxt    = LOAD_EST;
    valid_nxt   = 1'b0;
    timeout_nxt = TIMEOUT;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    hcnt_nxt    = hcnt;
    high_nxt    = HIGH_TIME;
`endif
    case (state)
      WAIT_LOW: begin
        if (primed && !s2) state_nxt = ARM;
      end
      ARM: begin
        if (rise) begin
          cnt_nxt   = 28'd1;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
          hcnt_nxt  = 28'd1;
`endif
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        // a rise on the MAX_COUNT cycle is still a valid measurement
        if (rise) begin
          period_nxt  = cnt;
          load_nxt    = {1'b0, cnt[27:1]};
          valid_nxt   = 1'b1;
          timeout_nxt = 1'b0;
          cnt_nxt     = 28'd1;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
          high_nxt    = hcnt;
          hcnt_nxt    = 28'd1;
`endif
        end else if (cnt == MAX_COUNT) begin
          timeout_nxt = 1'b1;
          period_nxt  = '0;
          load_nxt    = '0;
          cnt_nxt     = '0;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
          high_nxt    = '0;
          hcnt_nxt    = '0;
`endif
          state_nxt   = WAIT_LOW;
        end else begin
          cnt_nxt  = cnt + 28'd1;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
          hcnt_nxt = hcnt + {27'd0, s2};
`endif
        end
      end
      default: state_nxt = WAIT_LOW;
    endcase
  end

endmodule
